// File: rtl/mem_stage.sv
// mem_stage - memory-access stage of the sequential RV64 core.
//
// Accepts one Execute result per start pulse, performs at most one load or
// store over a request/ready data bus, then reports write-back data, the
// resolved next PC and a fault flag together with a one-cycle done pulse.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   start                Execute result valid (accepted only while idle)
//   MemRead, MemWrite    load / store instruction
//   Branch, Zero         conditional branch and ALU zero flag
//   funct3               access size / sign selector
//   ALU_result           effective address or pass-through result
//   B                    store data
//   Target, PC           branch target and current PC
//   mem_req/mem_we       bus request (held until mem_ready) and direction
//   mem_addr             doubleword-aligned address
//   mem_wdata/mem_wstrb  lane-shifted store data and byte enables
//   mem_rdata/mem_ready  read data and completion from the bus
//   busy, done           FSM not idle / one-cycle completion pulse
//   wb_data, next_pc     registered results, held until the next done
//   fault                misaligned or illegal access, valid with done
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALU_result,
  input  logic [63:0] B,
  input  logic        Zero,
  input  logic [63:0] Target,
  input  logic [63:0] PC,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] wb_data,
  output logic [63:0] next_pc,
  output logic        fault
);

  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_p0;
  state_t state_nxt;

  // Alignment / encoding check for an access that touches memory.
  // funct3[1:0] encodes the size for both loads and stores; funct3[2]
  // selects zero-extension on loads and is illegal on stores.
  function automatic logic access_ok(input logic       rd,
                                     input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [2:0] off);
    logic ok;
    if (rd && wr)                ok = 1'b0;
    else if (rd && f3 == 3'b111) ok = 1'b0;
    else if (wr && f3[2])        ok = 1'b0;
    else begin
      case (f3[1:0])
        2'd0:    ok = 1'b1;
        2'd1:    ok = ~off[0];
        2'd2:    ok = (off[1:0] == 2'b00);
        default: ok = (off == 3'b000);
      endcase
    end
    return ok;
  endfunction

  // Select the addressed bytes of the returned doubleword and extend.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] rdata,
                                                     input logic [2:0]        f3,
                                                     input logic [2:0]        off);
    logic        [DATA_W-1:0] sh;
    logic signed [7:0]        b8;
    logic signed [15:0]       h16;
    logic signed [31:0]       w32;
    logic signed [DATA_W-1:0] res;
    sh  = rdata >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    w32 = sh[31:0];
    case (f3)
      3'b000:  res = DATA_W'(b8);
      3'b001:  res = DATA_W'(h16);
      3'b010:  res = DATA_W'(w32);
      3'b100:  res = $signed({56'd0, sh[7:0]});
      3'b101:  res = $signed({48'd0, sh[15:0]});
      3'b110:  res = $signed({32'd0, sh[31:0]});
      default: res = $signed(sh);
    endcase
    return res;
  endfunction

  function automatic logic [STRB_W-1:0] store_strb(input logic [2:0] f3,
                                                   input logic [2:0] off);
    logic [STRB_W-1:0] mask;
    case (f3[1:0])
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [DATA_W-1:0] data,
                                                   input logic [2:0]        off);
    return data << {off, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] resolve_pc(input logic              br,
                                                   input logic              zero,
                                                   input logic [DATA_W-1:0] tgt,
                                                   input logic [DATA_W-1:0] pc);
    return (br && zero) ? tgt : pc + 64'd4;
  endfunction

  logic              is_mem_in;
  logic [2:0]        off_in;
  logic              ok_in;
  logic              go_access;
  logic              accept;
  logic [DATA_W-1:0] npc_in;

  assign is_mem_in = MemRead | MemWrite;
  assign off_in    = ALU_result[2:0];
  assign ok_in     = access_ok(MemRead, MemWrite, funct3, off_in);
  assign go_access = is_mem_in & ok_in;
  assign accept    = (state_p0 == IDLE) & start;
  assign npc_in    = resolve_pc(Branch, Zero, Target, PC);

  // Values held across the bus access; only needed once a legal access
  // has been launched, so they carry no reset.
  logic              rd_p0;
  logic [2:0]        f3_p0;
  logic [2:0]        off_p0;
  logic [DATA_W-1:0] npc_p0;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= IDLE;
    else        state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (start) state_nxt = go_access ? ACCESS : DONE;
      ACCESS:  if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_req follows the state directly so an asynchronous reset drops it
  // in the same cycle.
  assign mem_req = (state_p0 == ACCESS);
  assign busy    = (state_p0 != IDLE);
  assign done    = (state_p0 == DONE);

  // ---- capture stage: request context ----
  always_ff @(posedge clk) begin
    if (accept && go_access) begin
      rd_p0  <= MemRead;
      f3_p0  <= funct3;
      off_p0 <= off_in;
      npc_p0 <= npc_in;
    end
  end

  // ---- bus drive and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_data   <= '0;
      next_pc   <= '0;
      fault     <= 1'b0;
    end else begin
      if (accept) begin
        if (go_access) begin
          mem_we    <= MemWrite;
          mem_addr  <= {ALU_result[63:3], 3'b000};
          mem_wdata <= MemWrite ? store_data(B, off_in) : '0;
          mem_wstrb <= MemWrite ? store_strb(funct3, off_in) : '0;
        end else begin
          // Straight to DONE: pass-through result, or a faulting access.
          wb_data <= is_mem_in ? '0 : ALU_result;
          next_pc <= npc_in;
          fault   <= is_mem_in;
        end
      end else if (mem_req && mem_ready) begin
        wb_data <= rd_p0 ? load_extract(mem_rdata, f3_p0, off_p0) : '0;
        next_pc <= npc_p0;
        fault   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, MemRead, MemWrite, Branch, Zero;
  logic [2:0]  funct3;
  logic [63:0] ALU_result, B, Target, PC;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        busy, done;
  logic [63:0] wb_data, next_pc;
  logic        fault;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .funct3(funct3), .ALU_result(ALU_result), .B(B), .Zero(Zero),
    .Target(Target), .PC(PC), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .wb_data(wb_data),
    .next_pc(next_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [63:0] alu, b, rdata;
    int          wait_cyc;
    logic        br, zero;
    logic [63:0] tgt, pc;
    logic        bus;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wb, e_npc;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [63:0] wb, npc;
    logic        flt;
    int          lat;
  } exp_t;

  localparam logic [63:0] RD  = 64'h8877665544332211;
  localparam logic [63:0] PCB = 64'h100;
  localparam logic [63:0] TG  = 64'h400;
  localparam logic [63:0] NPC = 64'h104;
  localparam int NV = 21;

  vec_t        vecs[NV];
  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] prev_wb = '0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] alu, input logic [63:0] b,
                              input logic [63:0] rdata, input int wt,
                              input logic br, input logic zero,
                              input logic [63:0] tgt, input logic [63:0] pc,
                              input logic bus, input logic [63:0] e_addr,
                              input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                              input logic [63:0] e_wb, input logic [63:0] e_npc,
                              input logic e_fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.alu = alu; v.b = b; v.rdata = rdata;
    v.wait_cyc = wt; v.br = br; v.zero = zero; v.tgt = tgt; v.pc = pc; v.bus = bus;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    v.e_wb = e_wb; v.e_npc = e_npc; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic run_vec(input vec_t v, input bit intrude);
    exp_t e;
    int   cyc;
    int   waited;
    bit   saw_req;
    @(negedge clk);
    chk1("idle_done", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk("wb_hold", wb_data, prev_wb);
    MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; ALU_result = v.alu; B = v.b;
    Branch = v.br; Zero = v.zero; Target = v.tgt; PC = v.pc; start = 1'b1;
    e.wb = v.e_wb; e.npc = v.e_npc; e.flt = v.e_fault;
    e.lat = v.bus ? v.wait_cyc + 2 : 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0; cyc = 1; waited = 0; saw_req = 1'b0;
    if (intrude) begin
      MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b000; ALU_result = 64'h9999;
      B = '1; Branch = 1'b1; Zero = 1'b1; Target = 64'hBAD0; PC = 64'h7000;
      start = 1'b1;
    end
    while (!done && cyc < 64) begin
      if (mem_req) begin
        saw_req = 1'b1;
        chk("bus_addr", mem_addr, v.e_addr);
        chk1("bus_we", mem_we, v.wr);
        chk("bus_wstrb", 64'(mem_wstrb), 64'(v.e_wstrb));
        if (v.wr) chk("bus_wdata", mem_wdata, v.e_wdata);
        mem_rdata = v.rdata;
        mem_ready = (waited == v.wait_cyc);
        waited++;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    mem_ready = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done at %0d", cyc, e.lat);
    end else begin
      chk("wb_data", wb_data, e.wb);
      chk("next_pc", next_pc, e.npc);
      chk1("fault", fault, e.flt);
      chk("latency", 64'(cyc), 64'(e.lat));
      chk1("bus_used", saw_req, v.bus);
      prev_wb = e.wb;
    end
  endtask

  initial begin
    vecs[0]  = mk(1,0,3'b011,64'h1000,0,RD,3,0,0,TG,PCB,1,64'h1000,0,8'h00,RD,NPC,0);
    vecs[1]  = mk(1,0,3'b000,64'h1005,0,64'h00009C0000000000,0,0,0,TG,PCB,1,64'h1000,0,8'h00,64'hFFFFFFFFFFFFFF9C,NPC,0);
    vecs[2]  = mk(1,0,3'b100,64'h1005,0,64'h00009C0000000000,1,0,0,TG,PCB,1,64'h1000,0,8'h00,64'h9C,NPC,0);
    vecs[3]  = mk(0,1,3'b001,64'h2002,64'hABCD,0,0,0,0,TG,PCB,1,64'h2000,64'h00000000ABCD0000,8'h0C,0,NPC,0);
    vecs[4]  = mk(1,0,3'b010,64'h3002,0,RD,0,0,0,TG,PCB,0,0,0,8'h00,0,NPC,1);
    vecs[5]  = mk(1,1,3'b011,64'h4000,0,RD,0,0,0,TG,PCB,0,0,0,8'h00,0,NPC,1);
    vecs[6]  = mk(0,0,3'b000,64'h55,0,0,0,1,1,64'h400,64'h100,0,0,0,8'h00,64'h55,64'h400,0);
    vecs[7]  = mk(0,0,3'b000,64'h66,0,0,0,1,0,64'h400,64'h100,0,0,0,8'h00,64'h66,64'h104,0);
    vecs[8]  = mk(0,0,3'b000,64'h77,0,0,0,1,0,TG,64'hFFFFFFFFFFFFFFFC,0,0,0,8'h00,64'h77,64'h0,0);
    vecs[9]  = mk(1,0,3'b001,64'h1006,0,RD,2,0,0,TG,PCB,1,64'h1000,0,8'h00,64'hFFFFFFFFFFFF8877,NPC,0);
    vecs[10] = mk(1,0,3'b110,64'h1004,0,RD,0,0,0,TG,PCB,1,64'h1000,0,8'h00,64'h0000000088776655,NPC,0);
    vecs[11] = mk(1,0,3'b010,64'h1004,0,RD,1,0,0,TG,PCB,1,64'h1000,0,8'h00,64'hFFFFFFFF88776655,NPC,0);
    vecs[12] = mk(1,0,3'b101,64'h1002,0,RD,0,0,0,TG,PCB,1,64'h1000,0,8'h00,64'h4433,NPC,0);
    vecs[13] = mk(0,1,3'b011,64'h5008,64'h1122334455667788,0,1,1,1,64'h9000,PCB,1,64'h5008,64'h1122334455667788,8'hFF,0,64'h9000,0);
    vecs[14] = mk(0,1,3'b000,64'h6007,64'h123456789ABCDEEF,0,0,0,0,TG,PCB,1,64'h6000,64'hEF00000000000000,8'h80,0,NPC,0);
    vecs[15] = mk(0,1,3'b010,64'h7004,64'hDEADBEEFCAFEF00D,0,2,0,0,TG,PCB,1,64'h7000,64'hCAFEF00D00000000,8'hF0,0,NPC,0);
    vecs[16] = mk(0,1,3'b100,64'h8000,64'h1,0,0,0,0,TG,PCB,0,0,0,8'h00,0,NPC,1);
    vecs[17] = mk(1,0,3'b111,64'h8000,0,RD,0,0,0,TG,PCB,0,0,0,8'h00,0,NPC,1);
    vecs[18] = mk(1,0,3'b011,64'h1004,0,RD,0,1,1,64'h800,PCB,0,0,0,8'h00,0,64'h800,1);
    vecs[19] = mk(1,0,3'b011,64'hFFFFFFFFFFFFFFF8,0,RD,1,0,0,TG,64'hFFFFFFFFFFFFFFFC,1,64'hFFFFFFFFFFFFFFF8,0,8'h00,RD,64'h0,0);
    vecs[20] = mk(0,1,3'b001,64'h2001,64'hABCD,0,0,0,0,TG,PCB,0,0,0,8'h00,0,NPC,1);

    rst_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0;
    Zero = 1'b0; funct3 = 3'b000; ALU_result = '0; B = '0; Target = '0; PC = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_next_pc", next_pc, 64'h0);
    chk1("rst_fault", fault, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0);

    // start pulsed while busy must leave the first transaction untouched
    run_vec(vecs[0], 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk1("ignored_start_done", done, 1'b0);
      chk1("ignored_start_busy", busy, 1'b0);
    end
    chk("ignored_start_wb", wb_data, RD);

    // asynchronous reset in the middle of an access
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b011; ALU_result = 64'h1000;
    Branch = 1'b0; Zero = 1'b0; PC = PCB; Target = TG; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("pre_rst_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_req", mem_req, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_done", done, 1'b0);
    chk("async_rst_wb", wb_data, 64'h0);
    chk("async_rst_npc", next_pc, 64'h0);
    mem_rdata = RD; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    // a late bus response while idle must be ignored
    repeat (4) begin
      @(negedge clk);
      chk1("post_rst_done", done, 1'b0);
      chk1("post_rst_req", mem_req, 1'b0);
    end
    mem_ready = 1'b0;
    prev_wb = '0;

    // normal operation after reset
    run_vec(vecs[3], 1'b0);
    run_vec(vecs[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the sequential RISC-V core, directly downstream of the Execute stage. It consumes Execute's ALU_result, store operand, Zero and Target along with the decode control bits. It performs RV64 loads and stores over a request/ready data-memory bus and returns write-back data. It also produces the resolved next PC.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  Execute result valid; one-cycle pulse
- MemRead  in  1  load instruction
- MemWrite  in  1  store instruction
- Branch  in  1  conditional-branch instruction
- funct3  in  3  access size/sign selector
- ALU_result  in  64  effective address, or pass-through result
- B  in  64  store data (rs2)
- Zero  in  1  ALU zero flag
- Target  in  64  branch target from Execute
- PC  in  64  PC of the current instruction
- mem_req  out  1  bus request; held until mem_ready
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  64  doubleword-aligned address ({addr[63:3],3'b000})
- mem_wdata  out  64  store data shifted into byte lanes
- mem_wstrb  out  8  byte-lane enables (all 0 on reads)
- mem_rdata  in  64  read doubleword
- mem_ready  in  1  bus completion; sampled only while mem_req=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- wb_data  out  64  load result / pass-through value
- next_pc  out  64  resolved next PC
- fault  out  1  misaligned or illegal access; valid with done

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE
  - On start, capture all inputs.
  - If the access is a legal memory op, go to ACCESS.
  - Otherwise (non-memory op or fault), go to DONE.
- ACCESS
  - mem_req=1.
  - On mem_ready: capture mem_rdata, go to DONE.
- DONE
  - done=1 for exactly one cycle, then go to IDLE.
- start is accepted only when busy=0. start while busy is ignored, with no effect on the captured values.
- Let off = addr[2:0].
- Load funct3 values:
  - 000 LB, 100 LBU: any off.
  - 001 LH, 101 LHU: off[0]=0.
  - 010 LW, 110 LWU: off[1:0]=0.
  - 011 LD: off=0.
  - 111: illegal.
- Store funct3 values:
  - 000 SB, 001 SH, 010 SW, 011 SD: same alignment rules as the loads.
  - 100-111: illegal.
- Fault conditions: misalignment, illegal funct3, or MemRead&MemWrite both set.
  - fault=1, no bus transaction, wb_data=0.
- Load data path:
  - Select bytes rdata >> (8*off).
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend.
- Store data path:
  - mem_wdata = B << (8*off).
  - mem_wstrb = size mask << off (size masks: 0x01, 0x03, 0x0F, 0xFF).
  - No read-modify-write.
- Store result: wb_data=0.
- Non-memory op (MemRead=MemWrite=0): wb_data = captured ALU_result.
- next_pc:
  - = Target if (Branch & Zero), else PC + 4.
  - 64-bit modulo arithmetic; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
  - Computed for every instruction, faults included.
- wb_data, next_pc and fault are registered and update on entry to DONE. They hold until the next DONE.

## Timing
- Reset: state=IDLE; all outputs (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, wb_data, next_pc, fault) = 0.
- Reset mid-ACCESS drops mem_req immediately, asynchronously; any pending bus response is discarded.
- Memory op: start sampled at edge N.
  - mem_req is high from cycle N+1.
  - If mem_ready is high at edge N+1+k, done is high in cycle N+2+k.
  - Minimum latency is 2 cycles.
- Non-memory op or fault: done is high in cycle N+1 (latency 1); mem_req never rises.
- mem_addr, mem_we, mem_wdata and mem_wstrb are stable for the whole time mem_req=1.
- mem_ready while mem_req=0 is ignored.
- Back-to-back: start may be accepted in the cycle after done, i.e. when busy returns to 0.

## Test plan
- LD: ALU_result=0x1000, mem_rdata=0x8877665544332211, mem_ready after 3 wait cycles → mem_addr=0x1000, wstrb=0x00; done 5 cycles after start; wb_data=0x8877665544332211.
- LB / LBU: addr=0x1005, rdata byte5=0x9C → LB wb_data=0xFFFF_FFFF_FFFF_FF9C; LBU wb_data=0x9C.
- SH: addr=0x2002, B=0xABCD → mem_addr=0x2000, wstrb=0x0C, wdata=0x0000_0000_ABCD_0000, mem_we=1.
- Faults:
  - LW at addr=0x3002 → done 1 cycle after start, fault=1, mem_req stays 0.
  - MemRead=MemWrite=1 → fault=1.
- Branch: Branch=1, Zero=1, Target=0x400, PC=0x100 → next_pc=0x400.
  - Zero=0 → next_pc=0x104.
  - PC=0xFFFF_FFFF_FFFF_FFFC with Zero=0 → next_pc=0.
- Reset/ignore:
  - rst_n low during ACCESS → mem_req=0 and busy=0 the same cycle, no done.
  - start pulsed while busy=1 → ignored, first transaction completes unchanged.
